// File: rtl/edge_pkg.sv
// Shared definitions for the row fetch engine: frame geometry defaults,
// derived address constants, the control state type and geometry helpers.
package edge_pkg;

    localparam int DEF_WIDTH  = 352;
    localparam int DEF_HEIGHT = 288;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;

    // Geometry derived from the default frame size.
    localparam int ROW_WIDTH  = DEF_WIDTH / 4;
    localparam int MAX_ADDR   = (DEF_WIDTH * DEF_HEIGHT) / 4 - 1;
    localparam int OUT_BASE   = MAX_ADDR + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Words per row: four pixels are packed into each 32-bit word.
    function automatic int calc_row_width(input int width);
        return width / 4;
    endfunction

    // Address of the last input word of a frame.
    function automatic int calc_max_addr(input int width, input int height);
        return (width * height) / 4 - 1;
    endfunction

endpackage

// File: rtl/line_fifo.sv
// Fixed-depth shift-register line buffer. Every enabled cycle pushes one
// word in and exposes the word pushed DEPTH enables earlier on dout.
module line_fifo
    import edge_pkg::*;
#(
    parameter int DEPTH = ROW_WIDTH,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] taps_r [DEPTH];

    // Shift the whole line by one word on each enable; reset and clear empty it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps_r[i] <= {DW{1'b0}};
            end
        end else if (en) begin
            taps_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps_r[i] <= taps_r[i-1];
            end
        end
    end

    assign dout = taps_r[DEPTH-1];

endmodule

// File: rtl/row_fetch.sv
// row_fetch: streams a frame out of word memory through two line buffers so
// the accelerator sees a vertical three-row window (rows r-1, r, r+1 of one
// column) and stores the accelerator's result words in the output region
// that follows the input frame in the same memory.
module row_fetch
    import edge_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        acc_en,
    input  logic        acc_we,
    input  logic [31:0] acc_dataW,
    input  logic        acc_finish,
    output logic [31:0] dataRa,
    output logic [31:0] dataRb,
    output logic [31:0] dataRc,
    output logic        row_cached,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        finish
);

    localparam int          ROW_WORDS = calc_row_width(WIDTH);
    localparam logic [15:0] LAST_ADDR = 16'(calc_max_addr(WIDTH, HEIGHT));
    localparam logic [15:0] OUT_START = 16'(calc_max_addr(WIDTH, HEIGHT) + 1);
    localparam logic [15:0] ROW_LAST  = 16'(ROW_WORDS - 1);
    localparam logic [15:0] ROW_FULL  = 16'(ROW_WORDS);

    state_t      state_r;
    state_t      state_next_s;

    logic [15:0] rd_addr_r;
    logic [15:0] wr_addr_r;
    logic [15:0] fill_cnt_r;

    // Two-stage read pipeline: request issued -> memory data valid.
    logic        rd_req_r;
    logic        rd_req_pad_r;
    logic        rd_valid_r;
    logic        rd_valid_pad_r;

    logic        frame_start_s;
    logic        read_cycle_s;
    logic        write_cycle_s;
    logic        rd_in_range_s;
    logic        last_write_s;
    logic        shift_s;
    logic        fill_done_s;
    logic        in_frame_next_s;
    logic [31:0] incoming_s;
    logic [31:0] fifo1_out_s;
    logic [31:0] fifo2_out_s;

    assign rd_in_range_s   = (rd_addr_r <= LAST_ADDR);
    assign shift_s         = rd_valid_r;
    // Reads past the last frame word feed zeros in as the bottom padding row.
    assign incoming_s      = rd_valid_pad_r ? 32'h0000_0000 : mem_rdata;
    assign last_write_s    = write_cycle_s & (wr_addr_r == LAST_ADDR);
    assign fill_done_s     = shift_s & (fill_cnt_r == ROW_LAST);
    assign in_frame_next_s = (state_next_s == ST_FILL) || (state_next_s == ST_RUN);

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; dropping start always returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (!start) begin
                    state_next_s = ST_IDLE;
                end else if (fill_done_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_RUN: begin
                if (!start) begin
                    state_next_s = ST_IDLE;
                end else if (last_write_s || acc_finish) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Per-state decode of accelerator requests into read/write cycles.
    always_comb begin
        frame_start_s = 1'b0;
        read_cycle_s  = 1'b0;
        write_cycle_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                frame_start_s = start;
            end
            ST_FILL: begin
                read_cycle_s = acc_en & ~acc_we;
            end
            ST_RUN: begin
                read_cycle_s  = acc_en & ~acc_we;
                write_cycle_s = acc_en & acc_we & (wr_addr_r <= LAST_ADDR);
            end
            ST_DONE: begin
                frame_start_s = 1'b0;
            end
            default: begin
                frame_start_s = 1'b0;
            end
        endcase
    end

    // Read/write address counters; read address saturates one past the frame.
    always_ff @(posedge clk) begin
        if (rst || frame_start_s) begin
            rd_addr_r <= 16'd0;
            wr_addr_r <= 16'd0;
        end else begin
            if (read_cycle_s && rd_in_range_s) begin
                rd_addr_r <= rd_addr_r + 16'd1;
            end
            if (write_cycle_s) begin
                wr_addr_r <= wr_addr_r + 16'd1;
            end
        end
    end

    // Read pipeline tracking; reset or a new frame discards in-flight reads.
    always_ff @(posedge clk) begin
        if (rst || frame_start_s) begin
            rd_req_r       <= 1'b0;
            rd_req_pad_r   <= 1'b0;
            rd_valid_r     <= 1'b0;
            rd_valid_pad_r <= 1'b0;
        end else begin
            rd_req_r       <= read_cycle_s;
            rd_req_pad_r   <= read_cycle_s & ~rd_in_range_s;
            rd_valid_r     <= rd_req_r;
            rd_valid_pad_r <= rd_req_pad_r;
        end
    end

    // Registered memory port; address and write data hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 32'h0000_0000;
        end else if (frame_start_s) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end else if (read_cycle_s && rd_in_range_s) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= rd_addr_r;
        end else if (write_cycle_s) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= OUT_START + wr_addr_r;
            mem_wdata <= acc_dataW;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
        end
    end

    // Window registers and fill counter advance together on each valid word.
    always_ff @(posedge clk) begin
        if (rst || frame_start_s) begin
            dataRa     <= 32'h0000_0000;
            dataRb     <= 32'h0000_0000;
            dataRc     <= 32'h0000_0000;
            fill_cnt_r <= 16'd0;
        end else if (shift_s) begin
            dataRc <= incoming_s;
            dataRb <= fifo1_out_s;
            dataRa <= fifo2_out_s;
            if (fill_cnt_r != ROW_FULL) begin
                fill_cnt_r <= fill_cnt_r + 16'd1;
            end
        end
    end

    // Frame status flags: row_cached latches once primed, finish mirrors DONE.
    always_ff @(posedge clk) begin
        if (rst || frame_start_s) begin
            row_cached <= 1'b0;
            finish     <= 1'b0;
        end else begin
            finish <= (state_next_s == ST_DONE);
            if (in_frame_next_s) begin
                row_cached <= row_cached | fill_done_s;
            end else begin
                row_cached <= 1'b0;
            end
        end
    end

    line_fifo #(
        .DEPTH (ROW_WORDS),
        .DW    (32)
    ) u_fifo1 (
        .clk  (clk),
        .rst  (rst),
        .clr  (frame_start_s),
        .en   (shift_s),
        .din  (incoming_s),
        .dout (fifo1_out_s)
    );

    line_fifo #(
        .DEPTH (ROW_WORDS),
        .DW    (32)
    ) u_fifo2 (
        .clk  (clk),
        .rst  (rst),
        .clr  (frame_start_s),
        .en   (shift_s),
        .din  (fifo1_out_s),
        .dout (fifo2_out_s)
    );

endmodule
